// File: rtl/fp_sqrt_param.sv
// fp_sqrt_param: parameterised IEEE-style square root, one root bit per cycle
// with a valid/ready handshake on both sides and selectable rounding mode.
module fp_sqrt_param #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_data,
   input  logic [1:0]             round_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_data,
   output logic                   is_nan,
   output logic                   is_pinf,
   output logic                   is_ninf,
   output logic                   is_inexact
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int N  = MAN_W + 2;
   localparam int EW = EXP_W + 6;
   localparam logic [EXP_W-1:0] BIAS = {1'b0, {(EXP_W-1){1'b1}}};

   typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;

   state_t                 state;
   logic [W-1:0]           op;
   logic [1:0]             rm;
   logic [2*N-1:0]         x;
   logic [N+1:0]           rem;
   logic [N-1:0]           q;
   logic [4:0]             cnt;
   logic [EXP_W-1:0]       er;

   logic                   sgn, nan, pinf, zero, ge, g, st, inc;
   logic [EXP_W-1:0]       e, er_n;
   logic [MAN_W-1:0]       m;
   logic [MAN_W:0]         sig, sig_n, frac;
   logic [4:0]             s;
   logic signed [EW-1:0]   ue;
   logic [2*N-1:0]         x_init;
   logic [N+1:0]           rem_t, trial;
   logic [W-1:0]           res;

   assign in_ready = (state == IDLE) & ~reset;
   assign is_ninf  = 1'b0;

   always_comb begin
      sgn = op[W-1];
      e = op[W-2:MAN_W];
      m = op[MAN_W-1:0];
      sig = {|e, m};
      s = '0;
      for (int i = 0; i <= MAN_W; i++)
         if (sig[i]) s = 5'(MAN_W - i);
      sig_n = sig << s;
      // subnormals use exponent 1 and lose one more per normalising shift
      ue = EW'(e) + EW'(e == '0) - EW'(BIAS) - EW'(s);
      er_n = EXP_W'(ue >>> 1) + BIAS;
      x_init = ue[0] ? {sig_n, {(MAN_W+3){1'b0}}} : {1'b0, sig_n, {(MAN_W+2){1'b0}}};
      nan = (&e & |m) | (sgn & (|e | |m));
      pinf = &e & ~|m & ~sgn;
      zero = ~|{e, m};
      rem_t = {rem[N-1:0], x[2*N-1 -: 2]};
      trial = {q, 2'b01};
      ge = rem_t >= trial;
      g = q[0];
      st = |rem;
      inc = (rm == 2'b00) ? g & (st | q[1]) : (rm == 2'b10) ? g | st : 1'b0;
      frac = {1'b0, q[N-2:1]} + {{MAN_W{1'b0}}, inc};
      res = {1'b0, er + {{(EXP_W-1){1'b0}}, frac[MAN_W]}, frac[MAN_W-1:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         out_valid <= 1'b0;
         out_data <= '0;
         is_nan <= 1'b0;
         is_pinf <= 1'b0;
         is_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op <= in_data;
               rm <= round_mode;
               state <= NORM;
            end
            NORM: begin
               is_nan <= nan;
               is_pinf <= pinf;
               is_inexact <= 1'b0;
               out_data <= nan  ? {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                           pinf ? {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                  {sgn, {(W-1){1'b0}}};
               out_valid <= nan | pinf | zero;
               x <= x_init;
               rem <= '0;
               q <= '0;
               cnt <= '0;
               er <= er_n;
               state <= (nan | pinf | zero) ? DONE : ITER;
            end
            ITER: begin
               x <= x << 2;
               rem <= ge ? rem_t - trial : rem_t;
               q <= {q[N-2:0], ge};
               cnt <= cnt + 5'd1;
               if (cnt == 5'(N-1)) state <= ROUND;
            end
            ROUND: begin
               out_data <= res;
               is_inexact <= g | st;
               out_valid <= 1'b1;
               state <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
